bcd_tick_counter: RTL and testbench
===================================

// Module: bcd_tick_counter
//
// PURPOSE
//   Counts rising edges of the slow divided-clock level produced by the upstream clock divider.
//   The divided clock is used as data, never as a clock; the whole block runs on the fast clock.
//   Holds a DIGITS-wide packed BCD count that rolls over 99..9 -> 00..0.
//   Emits a one-cycle wrap pulse on rollover so instances can be chained as cascaded decade counters.
//
// PARAMETERS
//   DIGITS        4   number of BCD decades; count width = 4*DIGITS
//   EDGE_FALLING  0   0: count rising edges of tick_in; 1: count falling edges
//
// PORTS
//   clk_in    in   1          system clock; all state updates on posedge
//   rst       in   1          synchronous, active-high reset
//   tick_in   in   1          divided-clock level, registered in the clk_in domain upstream
//   en        in   1          1: detected edges increment count; 0: edges dropped
//   clr       in   1          synchronous clear of count
//   count     out  4*DIGITS   packed BCD, digit 0 in bits [3:0]
//   wrap      out  1          one-cycle pulse, all-9s -> 0 rollover
//
// BEHAVIOUR
//   - Reset: one clock, synchronous, active-high (rst); no asynchronous paths.
//   - Reset values: count=0, wrap=0, tick_q=1 (tick_q=0 when EDGE_FALLING=1).
//     A tick_in already at the active level when reset is released is not counted.
//   - Edge detect: one register tick_q <= tick_in each cycle, including when en=0.
//     Rising edge: evt = tick_in & ~tick_q. EDGE_FALLING=1: evt = ~tick_in & tick_q.
//   - Latency: count updates on the same clk_in edge that samples evt=1,
//     i.e. it is visible 1 cycle after tick_in first goes high.
//   - Priority, highest first: rst > clr > load (if compiled in) > increment (evt & en).
//   - Increment: digit 0 adds 1; digit k carries in when all lower digits = 9;
//     a carried digit at 9 goes to 0. No digit ever leaves 0..9.
//   - wrap: registered; 1 for exactly the cycle in which count shows 0 after an
//     increment from all-9s. Otherwise 0, including after clr, rst or load.
//   - en=0 while evt=1: the edge is lost, not queued; tick_q still updates.
//   - clr with evt on the same cycle: count=0, wrap=0, the edge is lost.
//   - Max event rate: 1 per 2 cycles, bounded by tick_in toggling. Consecutive events increment normally.
//
// CONFIGURATION
//   BCD_TICK_COUNTER_LOAD_EN defined:
//     adds ports load (in, 1) and load_val (in, 4*DIGITS).
//     load=1 sets count = load_val, with any digit > 9 clamped to 9; wrap=0 that cycle.
//     load beats a simultaneous increment, and that edge is lost; clr beats load.
//   Macro undefined: load and load_val do not exist; count changes only by rst, clr or increment.
//
// STRUCTURE
//   clock_pkg: typedef logic [3:0] bcd_t; localparam bcd_t BCD_MAX = 4'd9;
//     function bcd_clamp(bcd_t) returns a valid BCD digit.
//   Sub-module bcd_digit: one decade with ports clk_in, rst, clr, inc, ld, ld_val, q, carry_out.
//     carry_out = inc & (q==9), combinational.
//     The top generates DIGITS instances in a ripple-carry chain.
//   Top holds tick_q, evt logic and the wrap register.
//
// TESTING
//   1. rst released with tick_in=1 held, then 0->1 -> no count on release; count=0001 one cycle after the edge.
//   2. DIGITS=4, drive tick_in from a 10:1 divider for 25 periods -> count=0025, BCD valid each cycle, no hex digits.
//   3. Preset to 9999 (load or 9999 ticks), one more edge -> count=0000, wrap=1 for exactly 1 cycle.
//   4. en=0 across 3 edges, then en=1 for 2 edges -> count advances by 2 only.
//   5. clr and an edge on the same cycle -> count=0000, wrap=0; next edge -> 0001.
//   6. With BCD_TICK_COUNTER_LOAD_EN: load_val=0x12F4 -> count=0x1294.
//      load coincident with an edge -> count=load_val, not +1.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared BCD digit type, digit limit and clamp helper for the decade counters.
package clock_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Forces any nibble into the legal decimal range 0..9.
    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade of the tick counter.
// Ports:
//   clk_in    - system clock
//   rst       - synchronous active-high reset
//   clr       - synchronous clear, beats ld and inc
//   inc       - increment request (carry from the lower decade)
//   ld        - load ld_val (clamped to 9), beats inc
//   ld_val    - load value for this decade
//   q         - registered digit value, always 0..9
//   carry_out - combinational: inc while this digit is 9
module bcd_digit
    import clock_pkg::*;
(
    input  logic clk_in,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  logic ld,
    input  bcd_t ld_val,
    output bcd_t q,
    output logic carry_out
);

    bcd_t q_q;
    bcd_t q_d;

    // Next digit value: clr > ld > inc.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (ld) begin
            q_d = bcd_clamp(ld_val);
        end else if (inc) begin
            // >= also recovers an illegal value rather than letting it run into hex.
            q_d = (q_q >= BCD_MAX) ? '0 : bcd_t'(q_q + 4'd1);
        end
    end

    // Digit register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q         = q_q;
    assign carry_out = inc & (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_tick_counter.sv
// Cascadable BCD counter of edges on a divided-clock level sampled as data.
// Optional parallel load is compiled in with BCD_TICK_COUNTER_LOAD_EN.
// Parameters:
//   DIGITS       - number of BCD decades (count is 4*DIGITS bits)
//   EDGE_FALLING - 0: count rising edges of tick_in, 1: count falling edges
// Ports:
//   clk_in   - system clock, all state on posedge
//   rst      - synchronous active-high reset
//   tick_in  - divided-clock level, already in the clk_in domain
//   en       - 1: detected edges increment; 0: edges dropped
//   clr      - synchronous clear of count
//   load     - (BCD_TICK_COUNTER_LOAD_EN) load count from load_val
//   load_val - (BCD_TICK_COUNTER_LOAD_EN) packed BCD load value, digits > 9 clamp to 9
//   count    - packed BCD count, digit 0 in bits [3:0]
//   wrap     - one-cycle pulse when count rolls from all-9s to 0
module bcd_tick_counter
    import clock_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter bit          EDGE_FALLING = 1'b0
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    tick_in,
    input  logic                    en,
    input  logic                    clr,
`ifdef BCD_TICK_COUNTER_LOAD_EN
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
`endif
    output logic [BCD_W*DIGITS-1:0] count,
    output logic                    wrap
);

    localparam int unsigned CNT_W = BCD_W * DIGITS;

    // Reset tick_q to the active level so a level already active at release is not an edge.
    localparam logic TICK_RST = EDGE_FALLING ? 1'b0 : 1'b1;

    logic             tick_q;
    logic             wrap_q;
    logic             wrap_d;
    logic             evt_c;
    logic             load_c;
    logic [CNT_W-1:0] load_val_c;
    logic [DIGITS:0]  carry_c;

`ifdef BCD_TICK_COUNTER_LOAD_EN
    assign load_c     = load;
    assign load_val_c = load_val;
`else
    assign load_c     = 1'b0;
    assign load_val_c = '0;
`endif

    // Edge detect on the sampled level.
    assign evt_c = EDGE_FALLING ? (~tick_in & tick_q) : (tick_in & ~tick_q);

    // Ripple carry: decade 0 increments on an enabled edge, each higher decade on carry.
    assign carry_c[0] = evt_c & en;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk_in    (clk_in),
            .rst       (rst),
            .clr       (clr),
            .inc       (carry_c[g]),
            .ld        (load_c),
            .ld_val    (load_val_c[g*BCD_W +: BCD_W]),
            .q         (count[g*BCD_W +: BCD_W]),
            .carry_out (carry_c[g+1])
        );
    end

    // Rollover only counts when the increment actually lands (clr and load override it).
    assign wrap_d = carry_c[DIGITS] & ~clr & ~load_c;

    // Edge history and wrap pulse registers.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            tick_q <= TICK_RST;
            wrap_q <= 1'b0;
        end else begin
            tick_q <= tick_in;
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Bench for bcd_tick_counter (DIGITS=4, rising edges): directed table, random phase,
// long divider runs to rollover, and load cases when BCD_TICK_COUNTER_LOAD_EN is defined.
module tb_bcd_tick_counter;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        tick_in;
    logic        en;
    logic        clr;
`ifdef BCD_TICK_COUNTER_LOAD_EN
    logic        load;
    logic [15:0] load_val;
`endif
    logic [15:0] count;
    logic        wrap;

    always #5 clk_in = ~clk_in;

    bcd_tick_counter #(.DIGITS(4), .EDGE_FALLING(1'b0)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .tick_in  (tick_in),
        .en       (en),
        .clr      (clr),
`ifdef BCD_TICK_COUNTER_LOAD_EN
        .load     (load),
        .load_val (load_val),
`endif
        .count    (count),
        .wrap     (wrap)
    );

    typedef struct {
        logic [15:0] c;
        logic        w;
        string       name;
    } exp_t;

    typedef struct {
        bit          r;
        bit          t;
        bit          e;
        bit          c;
        logic [15:0] exp_c;
        bit          exp_w;
        string       name;
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state: plain decimal integer.
    bit m_tickq = 1'b1;
    int m_count = 0;
    bit m_wrap  = 1'b0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    function automatic int clamp_dec(input logic [15:0] lv);
        int v = 0;
        int m = 1;
        for (int i = 0; i < 4; i++) begin
            int nib = int'(lv[i*4 +: 4]);
            if (nib > 9) nib = 9;
            v += nib * m;
            m *= 10;
        end
        return v;
    endfunction

    // Drive one cycle, predict, push expectation, then pop and compare after the edge.
    task automatic drive(input bit r, input bit t, input bit e, input bit c, input bit l,
                         input logic [15:0] lv, input bit use_tab, input logic [15:0] tc,
                         input bit tw, input string name);
        exp_t x;
        bit   ev;
        rst     = r;
        tick_in = t;
        en      = e;
        clr     = c;
`ifdef BCD_TICK_COUNTER_LOAD_EN
        load     = l;
        load_val = lv;
`endif
        if (r) begin
            m_count = 0;
            m_wrap  = 1'b0;
            m_tickq = 1'b1;
        end else begin
            ev      = t & ~m_tickq;
            m_tickq = t;
            m_wrap  = 1'b0;
            if (c) begin
                m_count = 0;
            end else if (l) begin
                m_count = clamp_dec(lv);
            end else if (ev && e) begin
                m_wrap  = (m_count == 9999);
                m_count = (m_count + 1) % 10000;
            end
        end
        x.c    = use_tab ? tc : to_bcd(m_count);
        x.w    = use_tab ? tw : m_wrap;
        x.name = name;
        sb_q.push_back(x);
        @(posedge clk_in);
        #1;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty, count=%h wrap=%b", name, count, wrap);
        end else begin
            x = sb_q.pop_front();
            if (count !== x.c || wrap !== x.w) begin
                n_err++;
                $display("FAIL %s: count=%h wrap=%b, expected count=%h wrap=%b",
                         x.name, count, wrap, x.c, x.w);
            end
        end
    endtask

    task automatic step(input bit t, input bit e, input bit c, input string name);
        drive(1'b0, t, e, c, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, name);
    endtask

    task automatic step_exp(input bit t, input logic [15:0] ec, input bit ew, input string name);
        drive(1'b0, t, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, ec, ew, name);
    endtask

    vec_t tab[22];

    initial begin
        tab[0]  = '{1, 1, 1, 0, 16'h0000, 0, "rst_state0"};
        tab[1]  = '{1, 1, 1, 0, 16'h0000, 0, "rst_state1"};
        tab[2]  = '{0, 1, 1, 0, 16'h0000, 0, "no_cnt_on_release"};
        tab[3]  = '{0, 1, 1, 0, 16'h0000, 0, "level_high_hold"};
        tab[4]  = '{0, 0, 1, 0, 16'h0000, 0, "tick_low"};
        tab[5]  = '{0, 1, 1, 0, 16'h0001, 0, "first_edge"};
        tab[6]  = '{0, 0, 1, 0, 16'h0001, 0, "after_first_edge"};
        tab[7]  = '{0, 1, 0, 0, 16'h0001, 0, "en0_edge1"};
        tab[8]  = '{0, 0, 0, 0, 16'h0001, 0, "en0_low1"};
        tab[9]  = '{0, 1, 0, 0, 16'h0001, 0, "en0_edge2"};
        tab[10] = '{0, 0, 0, 0, 16'h0001, 0, "en0_low2"};
        tab[11] = '{0, 1, 0, 0, 16'h0001, 0, "en0_edge3"};
        tab[12] = '{0, 0, 1, 0, 16'h0001, 0, "en1_low"};
        tab[13] = '{0, 1, 1, 0, 16'h0002, 0, "en1_edge1"};
        tab[14] = '{0, 0, 1, 0, 16'h0002, 0, "en1_low1"};
        tab[15] = '{0, 1, 1, 0, 16'h0003, 0, "en1_edge2"};
        tab[16] = '{0, 0, 1, 0, 16'h0003, 0, "en1_low2"};
        tab[17] = '{0, 1, 1, 1, 16'h0000, 0, "clr_with_edge"};
        tab[18] = '{0, 0, 1, 0, 16'h0000, 0, "after_clr"};
        tab[19] = '{0, 1, 1, 0, 16'h0001, 0, "edge_after_clr"};
        tab[20] = '{0, 1, 1, 0, 16'h0001, 0, "level_held"};
        tab[21] = '{0, 0, 1, 0, 16'h0001, 0, "table_end"};

        for (int i = 0; i < 22; i++) begin
            drive(tab[i].r, tab[i].t, tab[i].e, tab[i].c, 1'b0, 16'h0,
                  1'b1, tab[i].exp_c, tab[i].exp_w, tab[i].name);
        end

        // Random tick/en/clr activity checked against the model.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 31) == 0), "random");
        end

        // 10:1 divider for 25 periods from a cleared count.
        step(1'b0, 1'b1, 1'b1, "div_clr");
        for (int p = 0; p < 25; p++) begin
            for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, "div_high");
            for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, "div_low");
        end
        step_exp(1'b0, 16'h0025, 1'b0, "div_25");

        // Maximum event rate up to all-9s, then rollover.
        for (int i = 0; i < 9974; i++) begin
            step(1'b1, 1'b1, 1'b0, "fast_high");
            step(1'b0, 1'b1, 1'b0, "fast_low");
        end
        step_exp(1'b0, 16'h9999, 1'b0, "at_9999");
        step_exp(1'b1, 16'h0000, 1'b1, "rollover_wrap");
        step_exp(1'b0, 16'h0000, 1'b0, "wrap_one_cycle");
        step_exp(1'b1, 16'h0001, 1'b0, "after_rollover");

`ifdef BCD_TICK_COUNTER_LOAD_EN
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h12F4, 1'b1, 16'h1294, 1'b0, "load_clamp");
        step_exp(1'b0, 16'h1294, 1'b0, "load_hold");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0042, 1'b1, 16'h0042, 1'b0, "load_beats_edge");
        step_exp(1'b0, 16'h0042, 1'b0, "load_edge_lost");
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0777, 1'b1, 16'h0000, 1'b0, "clr_beats_load");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h9999, 1'b1, 16'h9999, 1'b0, "load_9999");
        step_exp(1'b1, 16'h0000, 1'b1, "load_rollover");
        step_exp(1'b0, 16'h0000, 1'b0, "load_wrap_end");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
